// File: rtl/enc_disp_pkg.sv
// Shared types and constants for the encoder shift/scale display block.
//  mode_t       : scaler mode selected by the debounced buttons
//  SEG_GLYPH    : active-low {a,b,c,d,e,f,g,dp} glyphs for digits 0..9
//  SEG_DASH     : overflow glyph, SEG_BLANK : all segments off
//  quad_step()  : quadrature step decode, +1 CW / -1 CCW / 0 none or illegal
//  btn_mode()   : one-hot button decode to mode_t
package enc_disp_pkg;

  typedef enum logic [2:0] {
    PASS = 3'd0,
    X2   = 3'd1,
    X4   = 3'd2,
    D2   = 3'd3,
    D4   = 3'd4
  } mode_t;

  localparam logic [7:0] SEG_GLYPH [0:9] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
  };
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Map the Gray code onto its position in the CW cycle 00>01>11>10, then
  // a position delta of 1 is CW, 3 is CCW, 0 or 2 is no step.
  function automatic logic signed [1:0] quad_step(input logic [1:0] prev,
                                                  input logic [1:0] cur);
    logic [1:0] ip, ic, d;
    ip = {prev[1], prev[1] ^ prev[0]};
    ic = {cur[1],  cur[1]  ^ cur[0]};
    d  = ic - ip;
    case (d)
      2'd1:    quad_step = 2'sb01;
      2'd3:    quad_step = 2'sb11;
      default: quad_step = 2'sb00;
    endcase
  endfunction

  function automatic mode_t btn_mode(input logic [3:0] b);
    case (b)
      4'b0001: btn_mode = X2;
      4'b0010: btn_mode = X4;
      4'b0100: btn_mode = D2;
      4'b1000: btn_mode = D4;
      default: btn_mode = PASS;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    seg_of = (d <= 4'd9) ? SEG_GLYPH[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one input bit per cycle.
//  CLK, RST_N : clock, async active-low reset
//  start      : load bin and begin (ignored while busy)
//  bin        : binary input, BIN_W bits
//  busy       : high for BIN_W cycles while shifting
//  done       : 1-cycle pulse when bcd/ovf are updated
//  bcd        : DIGITS packed BCD digits, digit 0 in [3:0]
//  ovf        : bin >= 10^DIGITS (bcd then holds the low digits only)
module bin2bcd_seq
  import enc_disp_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    sh;
  logic [4*DIGITS-1:0] acc, adj;
  logic                ovf_acc;
  logic [CW-1:0]       cnt;

  // add-3 on every digit >= 5 before the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // Lower digits never depend on higher ones, so a bit leaving the top digit
  // means the full result has a non-zero digit above DIGITS: sticky overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh      <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        acc     <= {adj[4*DIGITS-2:0], sh[BIN_W-1]};
        ovf_acc <= ovf_acc | adj[4*DIGITS-1];
        sh      <= sh << 1;
        cnt     <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= {adj[4*DIGITS-2:0], sh[BIN_W-1]};
          ovf  <= ovf_acc | adj[4*DIGITS-1];
        end
      end else if (start) begin
        sh      <= bin;
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CW'(BIN_W);
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_shift_scaler_disp.sv
// Encoder-driven one-hot ring (WIDTH visible bits + hidden zero slot),
// button-selected x2/x4/÷2/÷4 scaler, sequential BCD and multiplexed 7-seg.
//  CLK, RST_N : 50 MHz clock, async active-low reset
//  ENCODER    : raw quadrature {A,B}
//  BOTON      : raw buttons [0]=x2 [1]=x4 [2]=/2 [3]=/4, active-high
//  LEDS       : visible ring bits
//  SEG, AN    : active-low segments {a..g,dp} and digit enables (AN[0]=units)
//  VALUE      : scaled binary result, RW = WIDTH+2 bits
//  BUSY       : BCD conversion running
// Build option: define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module enc_shift_scaler_disp
  import enc_disp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 4,
  parameter int ENC_SAMPLE_CYC = 40000,
  parameter int DEBOUNCE_CYC   = 2500000,
  parameter int SCAN_CYC       = 83333,
  localparam int RW            = WIDTH + 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        ENCODER,
  input  logic [3:0]        BOTON,
  output logic [WIDTH-1:0]  LEDS,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN,
  output logic [RW-1:0]     VALUE,
  output logic              BUSY
);

  localparam int ETW = $clog2(ENC_SAMPLE_CYC + 1);
  localparam int DTW = $clog2(DEBOUNCE_CYC + 1);
  localparam int STW = $clog2(SCAN_CYC + 1);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------- encoder sampler and ring ----------------
  logic [1:0]        enc_s1, enc_s2, enc_prev;
  logic [ETW-1:0]    enc_tmr;
  logic              enc_tick;
  logic signed [1:0] step;
  logic [WIDTH:0]    ring;

  assign enc_tick = (enc_tmr == ETW'(ENC_SAMPLE_CYC - 1));
  assign step     = quad_step(enc_prev, enc_s2);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      enc_s1   <= '0;
      enc_s2   <= '0;
      enc_prev <= '0;
      enc_tmr  <= '0;
      ring     <= (WIDTH+1)'(1) << WIDTH;
    end else begin
      enc_s1  <= ENCODER;
      enc_s2  <= enc_s1;
      enc_tmr <= enc_tick ? '0 : enc_tmr + 1'b1;
      if (enc_tick) begin
        enc_prev <= enc_s2;
        case (step)
          2'sb01:  ring <= {ring[WIDTH-1:0], ring[WIDTH]};
          2'sb11:  ring <= {ring[0], ring[WIDTH:1]};
          default: ring <= ring;
        endcase
      end
    end
  end

  assign LEDS = ring[WIDTH-1:0];

  // ---------------- button debouncer ----------------
  logic [3:0]     btn_s1, btn_s2, btn_smp;
  logic [DTW-1:0] deb_tmr;
  logic           deb_tick;
  mode_t          mode;

  assign deb_tick = (deb_tmr == DTW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_smp <= '0;
      deb_tmr <= '0;
      mode    <= PASS;
    end else begin
      btn_s1  <= BOTON;
      btn_s2  <= btn_s1;
      deb_tmr <= deb_tick ? '0 : deb_tmr + 1'b1;
      if (deb_tick) begin
        btn_smp <= btn_s2;
        if (btn_s2 == btn_smp) mode <= btn_mode(btn_s2);
      end
    end
  end

  // ---------------- scaler ----------------
  logic [RW-1:0] v_ext, v_scl, val_d;

  assign v_ext = {2'b00, ring[WIDTH-1:0]};

  always_comb begin
    case (mode)
      X2:      v_scl = v_ext << 1;
      X4:      v_scl = v_ext << 2;
      D2:      v_scl = v_ext >> 1;
      D4:      v_scl = v_ext >> 2;
      default: v_scl = v_ext;
    endcase
  end

  // ---------------- BCD control ----------------
  // A change seen while busy is remembered and replayed once the running
  // conversion finishes; the converter is never aborted.
  logic                chg, pend, start, done, ovf, ovf_lat;
  logic [4*DIGITS-1:0] bcd, bcd_lat;

  assign chg   = (VALUE != val_d);
  assign start = !BUSY && (chg || pend);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALUE   <= '0;
      val_d   <= '0;
      pend    <= 1'b0;
      bcd_lat <= '0;
      ovf_lat <= 1'b0;
    end else begin
      VALUE <= v_scl;
      val_d <= VALUE;
      if (start)    pend <= 1'b0;
      else if (chg) pend <= 1'b1;
      if (done) begin
        bcd_lat <= bcd;
        ovf_lat <= ovf;
      end
    end
  end

  bin2bcd_seq #(.BIN_W(RW), .DIGITS(DIGITS)) u_bcd (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start),
    .bin   (VALUE),
    .busy  (BUSY),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  // ---------------- glyph selection ----------------
  logic [DIGITS-1:0]      blank;
  logic [DIGITS-1:0][7:0] glyph;

`ifdef LEAD_ZERO_BLANK_EN
  // walk down from the top digit while everything seen so far is zero
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero  = hi_zero && (bcd_lat[4*i +: 4] == 4'd0);
      blank[i] = (i != 0) && hi_zero;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_lat)       glyph[i] = SEG_DASH;
      else if (blank[i]) glyph[i] = SEG_BLANK;
      else               glyph[i] = seg_of(bcd_lat[4*i +: 4]);
    end
  end

  // ---------------- scan mux ----------------
  logic [STW-1:0] scan_tmr;
  logic           scan_tick;
  logic [IW-1:0]  idx;

  assign scan_tick = (scan_tmr == STW'(SCAN_CYC - 1));

  // SEG and AN both come from the same idx in the same register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_tmr <= '0;
      idx      <= '0;
      SEG      <= SEG_BLANK;
      AN       <= '1;
    end else begin
      scan_tmr <= scan_tick ? '0 : scan_tmr + 1'b1;
      if (scan_tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      SEG <= glyph[idx];
      AN  <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_enc_shift_scaler_disp.sv
module tb_enc_shift_scaler_disp;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int RW   = W + 2;
  localparam int ENC  = 4;
  localparam int DEB  = 8;
  localparam int SCAN = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [1:0]    ENCODER = 2'b00;
  logic [3:0]    BOTON = 4'b0000;

  logic [W-1:0]  leds, leds2;
  logic [7:0]    seg, seg2;
  logic [D-1:0]  an;
  logic [1:0]    an2;
  logic [RW-1:0] value, value2;
  logic          busy, busy2;

  always #5 CLK = ~CLK;

  enc_shift_scaler_disp #(.WIDTH(W), .DIGITS(D), .ENC_SAMPLE_CYC(ENC),
    .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)) u1 (
    .CLK(CLK), .RST_N(RST_N), .ENCODER(ENCODER), .BOTON(BOTON),
    .LEDS(leds), .SEG(seg), .AN(an), .VALUE(value), .BUSY(busy));

  enc_shift_scaler_disp #(.WIDTH(W), .DIGITS(2), .ENC_SAMPLE_CYC(ENC),
    .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN)) u2 (
    .CLK(CLK), .RST_N(RST_N), .ENCODER(ENCODER), .BOTON(BOTON),
    .LEDS(leds2), .SEG(seg2), .AN(an2), .VALUE(value2), .BUSY(busy2));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: ring position (W = hidden slot), encoder cycle index, buttons
  int         m_pos;
  int         m_idx;
  logic [3:0] m_btn;

  logic [7:0] cap  [0:D-1];
  logic [7:0] cap2 [0:1];

  int   busy_rises = 0;
  logic busy_q = 1'b0;
  always @(negedge CLK) begin
    if (busy && !busy_q) busy_rises <= busy_rises + 1;
    busy_q <= busy;
  end

  function automatic logic [1:0] gray(int k);
    case (k)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int model_leds();
    return (m_pos == W) ? 0 : (1 << m_pos);
  endfunction

  function automatic int model_value();
    int v;
    v = model_leds();
    case (m_btn)
      4'b0001: v = v * 2;
      4'b0010: v = v * 4;
      4'b0100: v = v / 2;
      4'b1000: v = v / 4;
      default: v = v;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] exp_glyph(int v, int i, int nd);
    int p;
    p = 1;
    for (int j = 0; j < nd; j++) p = p * 10;
    if (v >= p) return 8'hFD;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
`ifdef LEAD_ZERO_BLANK_EN
    if (i > 0 && v < p) return 8'hFF;
`endif
    case ((v / p) % 10)
      0: return 8'h03;
      1: return 8'h9F;
      2: return 8'h25;
      3: return 8'h0D;
      4: return 8'h99;
      5: return 8'h49;
      6: return 8'h41;
      7: return 8'h1F;
      8: return 8'h01;
      default: return 8'h09;
    endcase
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    ENCODER = 2'b00;
    BOTON = 4'b0000;
    m_pos = W; m_idx = 0; m_btn = 4'b0000;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic enc_move(int dir);
    m_idx = (m_idx + dir + 4) % 4;
    ENCODER = gray(m_idx);
    if (dir == 1)  m_pos = (m_pos + 1) % (W + 1);
    if (dir == -1) m_pos = (m_pos + W) % (W + 1);
    repeat (5 * ENC) @(negedge CLK);
  endtask

  task automatic press(logic [3:0] b);
    BOTON = b;
    m_btn = b;
    repeat (5 * DEB) @(negedge CLK);
  endtask

  task automatic settle();
    int n;
    repeat (3) @(negedge CLK);
    n = 0;
    while (busy && n < 100) begin @(negedge CLK); n++; end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL settle: BUSY still %0b after %0d cycles, required 0", busy, n);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic capture_main();
    logic [D-1:0] want;
    int n;
    for (int k = 0; k < D; k++) begin
      want = ~(D'(1) << k);
      n = 0;
      while (an !== want && n < 4 * D * SCAN) begin @(negedge CLK); n++; end
      if (an !== want) begin
        n_chk++; n_fail++;
        $display("FAIL scan_wait: AN=%b never reached %b", an, want);
      end
      cap[k] = seg;
    end
  endtask

  task automatic capture_u2();
    logic [1:0] want;
    int n;
    for (int k = 0; k < 2; k++) begin
      want = ~(2'(1) << k);
      n = 0;
      while (an2 !== want && n < 8 * SCAN) begin @(negedge CLK); n++; end
      if (an2 !== want) begin
        n_chk++; n_fail++;
        $display("FAIL scan2_wait: AN=%b never reached %b", an2, want);
      end
      cap2[k] = seg2;
    end
  endtask

  task automatic test_reset();
    logic [D-1:0] prev, want;
    int n;
    RST_N = 1'b0; ENCODER = 2'b00; BOTON = 4'b0000;
    m_pos = W; m_idx = 0; m_btn = 4'b0000;
    repeat (3) @(negedge CLK);
    n_chk++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL rst_seg: got %h want FF", seg); end
    n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL rst_an: got %b want 1111", an); end
    n_chk++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_leds: got %h want 00", leds); end
    n_chk++; if (value !== '0) begin n_fail++; $display("FAIL rst_value: got %0d want 0", value); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    RST_N = 1'b1;
    @(negedge CLK);
    n_chk++; if (an !== 4'b1110) begin n_fail++; $display("FAIL scan_first: got %b want 1110", an); end
    for (int k = 1; k <= D; k++) begin
      prev = an;
      n = 0;
      while (an === prev && n < 3 * SCAN) begin @(negedge CLK); n++; end
      want = ~(D'(1) << (k % D));
      n_chk++; if (an !== want) begin n_fail++; $display("FAIL scan_order%0d: got %b want %b", k, an, want); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    capture_main();
    for (int k = 0; k < D; k++) begin
      n_chk++;
      if (cap[k] !== exp_glyph(0, k, D)) begin
        n_fail++; $display("FAIL rst_disp%0d: got %h want %h", k, cap[k], exp_glyph(0, k, D));
      end
    end
  endtask

  task automatic test_cw();
    do_reset();
    repeat (3) enc_move(1);
    settle();
    n_chk++; if (leds !== 8'h04) begin n_fail++; $display("FAIL cw3_leds: got %h want 04", leds); end
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL cw3_value: got %0d want %0d", value, model_value()); end
    capture_main();
    for (int k = 0; k < D; k++) begin
      n_chk++;
      if (cap[k] !== exp_glyph(model_value(), k, D)) begin
        n_fail++; $display("FAIL cw3_disp%0d: got %h want %h", k, cap[k], exp_glyph(model_value(), k, D));
      end
    end
    repeat (6) enc_move(1);
    settle();
    n_chk++; if (leds !== 8'h00) begin n_fail++; $display("FAIL cw9_leds: got %h want 00", leds); end
    n_chk++; if (value !== '0) begin n_fail++; $display("FAIL cw9_value: got %0d want 0", value); end
  endtask

  task automatic test_ccw();
    do_reset();
    enc_move(-1);
    settle();
    n_chk++; if (leds !== 8'h80) begin n_fail++; $display("FAIL ccw_leds: got %h want 80", leds); end
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL ccw_value: got %0d want %0d", value, model_value()); end
    capture_u2();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (cap2[k] !== exp_glyph(model_value(), k, 2)) begin
        n_fail++; $display("FAIL ovf2_disp%0d: got %h want %h", k, cap2[k], exp_glyph(model_value(), k, 2));
      end
    end
  endtask

  task automatic test_scale();
    press(4'b0010);
    settle();
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL x4_value: got %0d want %0d", value, model_value()); end
    capture_main();
    for (int k = 0; k < D; k++) begin
      n_chk++;
      if (cap[k] !== exp_glyph(model_value(), k, D)) begin
        n_fail++; $display("FAIL x4_disp%0d: got %h want %h", k, cap[k], exp_glyph(model_value(), k, D));
      end
    end
    // glitch shorter than one debounce period must be ignored
    BOTON = 4'b0001;
    repeat (DEB / 2) @(negedge CLK);
    BOTON = 4'b0010;
    repeat (5 * DEB) @(negedge CLK);
    settle();
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL glitch_value: got %0d want %0d", value, model_value()); end
  endtask

  task automatic test_div();
    do_reset();
    enc_move(1);
    press(4'b1000);
    settle();
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL d4_value: got %0d want %0d", value, model_value()); end
    press(4'b0011);
    settle();
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL multi_value: got %0d want %0d", value, model_value()); end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] v0;
    int r0, n;
    do_reset();
    enc_move(1);
    settle();
    r0 = busy_rises;
    for (int s = 0; s < 2; s++) begin
      v0 = value;
      m_idx = (m_idx + 1) % 4;
      m_pos = (m_pos + 1) % (W + 1);
      ENCODER = gray(m_idx);
      n = 0;
      while (value === v0 && n < 20) begin @(negedge CLK); n++; end
      n_chk++;
      if (value === v0) begin n_fail++; $display("FAIL b2b_step%0d: VALUE stuck at %0d", s, value); end
    end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    repeat (5 * ENC) @(negedge CLK);
    settle();
    n_chk++; if (busy_rises - r0 != 2) begin n_fail++; $display("FAIL b2b_conv: got %0d conversions want 2", busy_rises - r0); end
    n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL b2b_value: got %0d want %0d", value, model_value()); end
    capture_main();
    for (int k = 0; k < D; k++) begin
      n_chk++;
      if (cap[k] !== exp_glyph(model_value(), k, D)) begin
        n_fail++; $display("FAIL b2b_disp%0d: got %h want %h", k, cap[k], exp_glyph(model_value(), k, D));
      end
    end
    enc_move(2);
    settle();
    n_chk++; if (leds !== 8'(model_leds())) begin n_fail++; $display("FAIL illegal_leds: got %h want %h", leds, 8'(model_leds())); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enc_move(-1);
    settle();
    BOTON = 4'b0010;
    n = 0;
    while (!busy && n < 100) begin @(negedge CLK); n++; end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_chk++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL mid_seg: got %h want FF", seg); end
    n_chk++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_an: got %b want 1111", an); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_chk++; if (value !== '0) begin n_fail++; $display("FAIL mid_value: got %0d want 0", value); end
    do_reset();
    settle();
    capture_main();
    for (int k = 0; k < D; k++) begin
      n_chk++;
      if (cap[k] !== exp_glyph(0, k, D)) begin
        n_fail++; $display("FAIL mid_disp%0d: got %h want %h", k, cap[k], exp_glyph(0, k, D));
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int it = 0; it < 14; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0, 1: enc_move(1);
        2:    enc_move(-1);
        3:    enc_move(2);
        default: press(4'($urandom_range(0, 15)));
      endcase
      settle();
      n_chk++; if (leds !== 8'(model_leds())) begin n_fail++; $display("FAIL rnd_leds%0d: got %h want %h", it, leds, 8'(model_leds())); end
      n_chk++; if (value !== RW'(model_value())) begin n_fail++; $display("FAIL rnd_value%0d: got %0d want %0d", it, value, model_value()); end
      capture_main();
      for (int k = 0; k < D; k++) begin
        n_chk++;
        if (cap[k] !== exp_glyph(model_value(), k, D)) begin
          n_fail++; $display("FAIL rnd_disp%0d_%0d: got %h want %h", it, k, cap[k], exp_glyph(model_value(), k, D));
        end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_scale();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
